mc_ctrl_ws: RTL and testbench

Parametrised multicycle MIPS-subset control FSM with instruction- and data-memory wait-state handshakes, overflow/illegal-opcode trap, and performance counters. Sits beside pc, npc, im, ir and the datapath in the multicycle CPU. It replaces the fixed-latency controller so that memories of any latency and a trap path can be attached without touching the datapath.

---
 rtl/mc_ctrl_pkg.sv | 68 ++++++
 rtl/mc_ctrl_ws_if.sv | 19 +
 rtl/mc_ctrl_decode.sv | 37 +++
 rtl/mc_ctrl_ws.sv | 205 ++++++++++++++++++++
 tb/tb_mc_ctrl_ws.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multicycle wait-state controller.
// Opcodes, functs, states, mux encodings and instruction classes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [2:0] NPC_PC4  = 3'b000;
  localparam logic [2:0] NPC_BEQ  = 3'b001;
  localparam logic [2:0] NPC_J    = 3'b010;
  localparam logic [2:0] NPC_JR   = 3'b011;
  localparam logic [2:0] NPC_TRAP = 3'b100;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DM    = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_UP   = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_SLT  = 2'b11;

  typedef enum logic [3:0] {
    C_ADDU = 4'd0,
    C_SUBU = 4'd1,
    C_SLT  = 4'd2,
    C_ORI  = 4'd3,
    C_LUI  = 4'd4,
    C_ADDI = 4'd5,
    C_LW   = 4'd6,
    C_SW   = 4'd7,
    C_BEQ  = 4'd8,
    C_J    = 4'd9,
    C_JR   = 4'd10,
    C_JAL  = 4'd11,
    C_NOP  = 4'd12
  } iclass_e;

endpackage

// File: rtl/mc_ctrl_ws_if.sv
// Instruction/data memory request-acknowledge bundle.
// master = controller side, slave = memory side.
interface mc_ctrl_ws_if;
  logic im_req;
  logic im_ack;
  logic dm_req;
  logic dm_ack;
  logic DMWr;

  modport master (
    output im_req, dm_req, DMWr,
    input  im_ack, dm_ack
  );

  modport slave (
    input  im_req, dm_req, DMWr,
    output im_ack, dm_ack
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct classifier.
// Unknown encodings come out as C_NOP with illegal set.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_e    cls,
  output logic       illegal
);

  always_comb begin
    cls     = C_NOP;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADDU: cls = C_ADDU;
          FN_SUBU: cls = C_SUBU;
          FN_SLT:  cls = C_SLT;
          FN_JR:   cls = C_JR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_ADDI: cls = C_ADDI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_ws.sv
// Multicycle MIPS-subset control FSM with memory wait states,
// overflow/illegal trap and cycle/retire counters.
module mc_ctrl_ws
  import mc_ctrl_pkg::*;
#(
  parameter bit OVF_TRAP = 1'b1,
  parameter bit ILL_TRAP = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  mc_ctrl_ws_if.master     mem,
  output logic             PCWr,
  output logic             IRWr,
  output logic             GPRWr,
  output logic             ALUSrc,
  output logic             epc_wr,
  output logic [2:0]       nPCsel,
  output logic [1:0]       regDst,
  output logic [1:0]       writeData,
  output logic [1:0]       extsel,
  output logic [1:0]       ALUsel,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  iclass_e    cls;
  logic       illegal;
  state_e     state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic       im_req, dm_req, dm_wr;
  logic       a_src;
  logic [1:0] a_ext, a_sel;
  logic       ovf_trap;

  mc_ctrl_decode u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .illegal (illegal)
  );

  assign ovf_trap = OVF_TRAP && (cls == C_ADDI) && overflow;

  always_comb begin
    a_src = 1'b0;
    a_ext = EXT_ZERO;
    a_sel = ALU_ADD;
    unique case (1'b1)
      cls == C_SUBU: a_sel = ALU_SUB;
      cls == C_SLT:  a_sel = ALU_SLT;
      cls == C_BEQ:  a_sel = ALU_SUB;
      cls == C_ORI: begin
        a_src = 1'b1;
        a_sel = ALU_OR;
      end
      cls == C_LUI: begin
        a_src = 1'b1;
        a_ext = EXT_UP;
        a_sel = ALU_OR;
      end
      cls == C_ADDI,
      cls == C_LW,
      cls == C_SW: begin
        a_src = 1'b1;
        a_ext = EXT_SIGN;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    im_req    = 1'b0;
    dm_req    = 1'b0;
    dm_wr     = 1'b0;
    PCWr      = 1'b0;
    IRWr      = 1'b0;
    GPRWr     = 1'b0;
    ALUSrc    = 1'b0;
    epc_wr    = 1'b0;
    nPCsel    = NPC_PC4;
    regDst    = RD_RT;
    writeData = WD_ALU;
    extsel    = EXT_ZERO;
    ALUsel    = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        im_req = 1'b1;
        if (mem.im_ack) begin
          PCWr    = 1'b1;
          IRWr    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (illegal && ILL_TRAP) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        ALUSrc  = a_src;
        extsel  = a_ext;
        ALUsel  = a_sel;
        state_d = S_FETCH;
        unique case (cls)
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ: begin
            PCWr   = zero;
            nPCsel = NPC_BEQ;
          end
          C_J: begin
            PCWr   = 1'b1;
            nPCsel = NPC_J;
          end
          C_JR: begin
            PCWr   = 1'b1;
            nPCsel = NPC_JR;
          end
          C_JAL: begin
            PCWr      = 1'b1;
            nPCsel    = NPC_J;
            GPRWr     = 1'b1;
            regDst    = RD_RA;
            writeData = WD_PC4;
          end
          C_NOP: ;
          default: state_d = ovf_trap ? S_TRAP : S_WB;
        endcase
      end
      S_MEM: begin
        ALUSrc = a_src;
        extsel = a_ext;
        ALUsel = a_sel;
        dm_req = 1'b1;
        dm_wr  = (cls == C_SW);
        if (mem.dm_ack)
          state_d = (cls == C_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        ALUSrc  = a_src;
        extsel  = a_ext;
        ALUsel  = a_sel;
        GPRWr   = 1'b1;
        regDst  = (opcode == OP_RTYPE) ? RD_RD : RD_RT;
        writeData = (cls == C_LW) ? WD_DM : WD_ALU;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        epc_wr  = 1'b1;
        PCWr    = 1'b1;
        nPCsel  = NPC_TRAP;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // reset silences every control line, even though state is FETCH
    if (reset) begin
      im_req    = 1'b0;
      dm_req    = 1'b0;
      dm_wr     = 1'b0;
      PCWr      = 1'b0;
      IRWr      = 1'b0;
      GPRWr     = 1'b0;
      ALUSrc    = 1'b0;
      epc_wr    = 1'b0;
      nPCsel    = NPC_PC4;
      regDst    = RD_RT;
      writeData = WD_ALU;
      extsel    = EXT_ZERO;
      ALUsel    = ALU_ADD;
    end
  end

  always_comb begin
    cyc_d = cyc_q + CNT_W'(1);
    ret_d = ret_q;
    if (state_d == S_FETCH && state_q != S_FETCH
        && state_q != S_TRAP)
      ret_d = ret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  assign mem.im_req = im_req;
  assign mem.dm_req = dm_req;
  assign mem.DMWr   = dm_wr;
  assign cyc_cnt    = cyc_q;
  assign ret_cnt    = ret_q;

endmodule

// File: tb/tb_mc_ctrl_ws.sv
// Directed bench for mc_ctrl_ws: ori, delayed lw, beq, jal,
// overflow/illegal traps and reset during a store.
module tb_mc_ctrl_ws;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, overflow;
  logic        PCWr, IRWr, GPRWr, ALUSrc, epc_wr;
  logic [2:0]  nPCsel;
  logic [1:0]  regDst, writeData, extsel, ALUsel;
  logic [31:0] cyc_cnt, ret_cnt;
  int          total = 0;
  int          bad = 0;

  mc_ctrl_ws_if mif ();

  mc_ctrl_ws dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .overflow  (overflow),
    .mem       (mif.master),
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .GPRWr     (GPRWr),
    .ALUSrc    (ALUSrc),
    .epc_wr    (epc_wr),
    .nPCsel    (nPCsel),
    .regDst    (regDst),
    .writeData (writeData),
    .extsel    (extsel),
    .ALUsel    (ALUsel),
    .cyc_cnt   (cyc_cnt),
    .ret_cnt   (ret_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    opcode = 6'b0;
    funct = 6'b0;
    zero = 1'b0;
    overflow = 1'b0;
    mif.im_ack = 1'b0;
    mif.dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_im_req", 32'(mif.im_req), 0);
    chk("rst_pcwr", 32'(PCWr), 0);
    chk("rst_cyc", cyc_cnt, 0);
    chk("rst_ret", ret_cnt, 0);

    // c1 FETCH ori, im_ack tied high
    @(negedge clk);
    reset = 1'b0;
    opcode = OP_ORI;
    mif.im_ack = 1'b1;
    #1;
    chk("c1_im_req", 32'(mif.im_req), 1);
    chk("c1_irwr", 32'(IRWr), 1);
    chk("c1_pcwr", 32'(PCWr), 1);
    chk("c1_cyc", cyc_cnt, 0);
    nxt(); // c2 DECODE
    chk("c2_im_req", 32'(mif.im_req), 0);
    chk("c2_gprwr", 32'(GPRWr), 0);
    nxt(); // c3 EXEC
    chk("c3_alusrc", 32'(ALUSrc), 1);
    chk("c3_alusel", 32'(ALUsel), 2);
    nxt(); // c4 WB
    chk("c4_gprwr", 32'(GPRWr), 1);
    chk("c4_regdst", 32'(regDst), 0);
    chk("c4_extsel", 32'(extsel), 0);
    chk("c4_ret", ret_cnt, 0);

    // c5 FETCH lw
    nxt();
    opcode = OP_LW;
    chk("c5_ret", ret_cnt, 1);
    chk("c5_cyc", cyc_cnt, 4);
    chk("c5_im_req", 32'(mif.im_req), 1);
    nxt(); // c6 DECODE
    nxt(); // c7 EXEC
    chk("c7_extsel", 32'(extsel), 1);
    chk("c7_dm_req", 32'(mif.dm_req), 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); // c8..c10 MEM waiting
      chk("lw_wait_dm_req", 32'(mif.dm_req), 1);
      chk("lw_wait_dmwr", 32'(mif.DMWr), 0);
    end
    nxt(); // c11 MEM ack
    mif.dm_ack = 1'b1;
    #0;
    chk("c11_dm_req", 32'(mif.dm_req), 1);
    chk("c11_gprwr", 32'(GPRWr), 0);
    nxt(); // c12 WB
    mif.dm_ack = 1'b0;
    chk("c12_gprwr", 32'(GPRWr), 1);
    chk("c12_wdata", 32'(writeData), 1);
    chk("c12_dm_req", 32'(mif.dm_req), 0);

    // c13 FETCH stalled, stray dm_ack
    nxt();
    mif.im_ack = 1'b0;
    mif.dm_ack = 1'b1;
    #1;
    chk("c13_cyc", cyc_cnt, 12);
    chk("c13_ret", ret_cnt, 2);
    chk("c13_im_req", 32'(mif.im_req), 1);
    chk("c13_dm_req", 32'(mif.dm_req), 0);
    chk("c13_irwr", 32'(IRWr), 0);

    // c14 FETCH beq, zero=0
    nxt();
    mif.im_ack = 1'b1;
    mif.dm_ack = 1'b0;
    opcode = OP_BEQ;
    #1;
    chk("c14_im_req", 32'(mif.im_req), 1);
    chk("c14_cyc", cyc_cnt, 13);
    nxt(); // c15 DECODE
    nxt(); // c16 EXEC
    chk("beq0_pcwr", 32'(PCWr), 0);
    chk("beq0_npc", 32'(nPCsel), 1);
    chk("beq0_alusel", 32'(ALUsel), 1);

    // c17 FETCH beq, zero=1
    nxt();
    zero = 1'b1;
    chk("c17_cyc", cyc_cnt, 16);
    chk("c17_ret", ret_cnt, 3);
    nxt(); // c18
    nxt(); // c19 EXEC
    chk("beq1_pcwr", 32'(PCWr), 1);
    chk("beq1_npc", 32'(nPCsel), 1);

    // c20 FETCH jal
    nxt();
    zero = 1'b0;
    opcode = OP_JAL;
    chk("c20_cyc", cyc_cnt, 19);
    chk("c20_ret", ret_cnt, 4);
    nxt(); // c21
    nxt(); // c22 EXEC
    chk("jal_gprwr", 32'(GPRWr), 1);
    chk("jal_regdst", 32'(regDst), 2);
    chk("jal_wdata", 32'(writeData), 2);
    chk("jal_npc", 32'(nPCsel), 2);
    chk("jal_pcwr", 32'(PCWr), 1);

    // c23 FETCH addi with overflow
    nxt();
    opcode = OP_ADDI;
    chk("c23_ret", ret_cnt, 5);
    nxt(); // c24
    nxt(); // c25 EXEC
    overflow = 1'b1;
    #1;
    chk("ovf_gprwr", 32'(GPRWr), 0);
    chk("ovf_pcwr", 32'(PCWr), 0);
    nxt(); // c26 TRAP
    overflow = 1'b0;
    chk("ovf_epc", 32'(epc_wr), 1);
    chk("ovf_npc", 32'(nPCsel), 4);
    chk("ovf_pcwr2", 32'(PCWr), 1);
    chk("ovf_gprwr2", 32'(GPRWr), 0);

    // c27 FETCH illegal opcode
    nxt();
    opcode = 6'b111111;
    chk("c27_ret", ret_cnt, 5);
    chk("c27_cyc", cyc_cnt, 26);
    nxt(); // c28 DECODE
    chk("ill_dec_epc", 32'(epc_wr), 0);
    nxt(); // c29 TRAP
    chk("ill_epc", 32'(epc_wr), 1);
    chk("ill_npc", 32'(nPCsel), 4);

    // c30 FETCH addu, overflow ignored
    nxt();
    opcode = OP_RTYPE;
    funct = FN_ADDU;
    chk("c30_ret", ret_cnt, 5);
    chk("c30_cyc", cyc_cnt, 29);
    nxt(); // c31
    nxt(); // c32 EXEC
    overflow = 1'b1;
    #1;
    chk("addu_alusel", 32'(ALUsel), 0);
    chk("addu_alusrc", 32'(ALUSrc), 0);
    nxt(); // c33 WB
    overflow = 1'b0;
    chk("addu_gprwr", 32'(GPRWr), 1);
    chk("addu_regdst", 32'(regDst), 1);
    chk("addu_epc", 32'(epc_wr), 0);

    // c34 FETCH sw, reset pulsed mid-MEM
    nxt();
    opcode = OP_SW;
    funct = 6'b0;
    chk("c34_ret", ret_cnt, 6);
    nxt(); // c35
    nxt(); // c36 EXEC
    nxt(); // c37 MEM
    chk("sw_dm_req", 32'(mif.dm_req), 1);
    chk("sw_dmwr", 32'(mif.DMWr), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mem_dm_req", 32'(mif.dm_req), 0);
    chk("rst_mem_dmwr", 32'(mif.DMWr), 0);
    chk("rst_mem_im_req", 32'(mif.im_req), 0);
    chk("rst_mem_cyc", cyc_cnt, 0);
    chk("rst_mem_ret", ret_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    mif.dm_ack = 1'b1;
    #1;
    chk("post_im_req", 32'(mif.im_req), 1);
    chk("post_dm_req", 32'(mif.dm_req), 0);
    chk("post_dmwr", 32'(mif.DMWr), 0);
    chk("post_cyc", cyc_cnt, 0);
    nxt(); // DECODE
    mif.dm_ack = 1'b0;
    chk("post_dec_im_req", 32'(mif.im_req), 0);
    chk("post_dec_cyc", cyc_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
